// File: rtl/alu_compare_seq.sv
// rtl/alu_compare_seq.sv - multi-cycle chunked RISC-V compare unit with early exit
module alu_compare_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_result,
  output logic [WIDTH-1:0] o_lt_word,
  output logic             o_busy
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("alu_compare_seq: WIDTH must be divisible by CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [IDX_W-1:0] r_idx;
  logic             r_result;

  logic             w_signed;
  logic [WIDTH-1:0] w_flip;
  logic [WIDTH-1:0] w_a_adj;
  logic [WIDTH-1:0] w_b_adj;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic             w_diff;
  logic             w_lt;
  logic             w_last;
  logic             w_finish;
  logic             w_res;

  // Flipping the sign bit maps two's complement onto unsigned order, so the
  // MSB chunk compares correctly for signed modes and lower chunks are unchanged.
  assign w_signed = (r_op == 3'b010) || (r_op == 3'b100) || (r_op == 3'b101);
  assign w_flip   = {w_signed, {(WIDTH-1){1'b0}}};
  assign w_a_adj  = r_a ^ w_flip;
  assign w_b_adj  = r_b ^ w_flip;

  // Select the chunk pair addressed by the current scan index.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_chunk = w_a_adj[i*CHUNK +: CHUNK];
        w_b_chunk = w_b_adj[i*CHUNK +: CHUNK];
      end
    end
  end

  assign w_diff   = (w_a_chunk != w_b_chunk);
  assign w_lt     = (w_a_chunk < w_b_chunk);
  assign w_last   = (r_idx == '0);
  assign w_finish = w_diff || w_last;

  // Map the chunk outcome onto the requested compare mode; when all chunks
  // matched, w_lt is 0 and w_diff is 0, which gives eq=1 / lt=0.
  always_comb begin
    w_res = 1'b0;
    case (r_op)
      3'b000:                         w_res = !w_diff;
      3'b001:                         w_res = w_diff;
      3'b010, 3'b011, 3'b100, 3'b110: w_res = w_lt;
      default:                        w_res = !w_lt;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: accept in IDLE, scan until a difference or the last chunk,
  // hold the result until the consumer takes it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_valid)  w_next = S_SCAN;
      S_SCAN: if (w_finish) w_next = S_DONE;
      S_DONE: if (i_ready)  w_next = S_IDLE;
      default:              w_next = S_IDLE;
    endcase
  end

  // Operand capture, scan index walk and result register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_idx    <= '0;
      r_result <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && i_valid) begin
        r_a   <= i_a;
        r_b   <= i_b;
        r_op  <= i_op;
        r_idx <= IDX_W'(NUM_CHUNKS - 1);
      end
      if (r_state == S_SCAN) begin
        if (w_finish) begin
          r_result <= w_res;
        end else begin
          r_idx <= r_idx - 1'b1;
        end
      end
    end
  end

  assign o_ready   = (r_state == S_IDLE);
  assign o_valid   = (r_state == S_DONE);
  assign o_busy    = (r_state != S_IDLE);
  assign o_result  = r_result;
  assign o_lt_word = {{(WIDTH-1){1'b0}}, r_result};

endmodule
